// File: rtl/dsp_muladd_pipe.sv
// dsp_muladd_pipe: signed multiply-add / multiply-subtract / multiply-accumulate /
// multiply-only over a lat-stage pipeline with a travelling valid flag and a
// global enable that freezes every stage.
// Optional build macro DSP_MULADD_SAT_EN: when defined, y saturates on overflow
// instead of wrapping (the accumulator always stays full precision).
module dsp_muladd_pipe #(
    parameter int width     = 8,
    parameter int lat       = 2,
    parameter int acc_width = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [1:0]       mode,
    input  logic             acc_clr,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic [width-1:0] c,
    output logic             out_valid,
    output logic [width-1:0] y,
    output logic             overflow
);

    localparam int PW = 2 * width;
    localparam int RW = (2 * width + 1 > acc_width) ? 2 * width + 1 : acc_width;
    localparam int PD = (lat > 2) ? lat - 2 : 1;

    // Full-precision signed product of two width-bit operands.
    function automatic logic [PW-1:0] smul(input logic [width-1:0] x,
                                           input logic [width-1:0] z);
        logic signed [PW-1:0] xe;
        logic signed [PW-1:0] ze;
        xe = PW'($signed(x));
        ze = PW'($signed(z));
        return xe * ze;
    endfunction

`ifdef DSP_MULADD_SAT_EN
    // Clamp value for an out-of-range result of the given sign.
    function automatic logic [width-1:0] sat_value(input logic neg);
        logic [width-1:0] v;
        if (neg) begin
            v = {1'b1, {(width-1){1'b0}}};
        end else begin
            v = {1'b0, {(width-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    // Signals presented to the output (final add) stage.
    logic [PW-1:0]    fin_p_s;
    logic [width-1:0] fin_c_s;
    logic [1:0]       fin_mode_s;
    logic             fin_clr_s;
    logic             fin_valid_s;

    generate
        if (lat == 1) begin : g_lat1
            // Single-stage build: multiply and add both feed the output register.
            always_comb begin
                fin_p_s     = smul(a, b);
                fin_c_s     = c;
                fin_mode_s  = mode;
                fin_clr_s   = acc_clr;
                fin_valid_s = in_valid;
            end
        end else begin : g_latn
            logic [width-1:0] s1_a_q;
            logic [width-1:0] s1_b_q;
            logic [width-1:0] s1_c_q;
            logic [1:0]       s1_mode_q;
            logic             s1_clr_q;
            logic             s1_valid_q;
            logic [PW-1:0]    s1_p_s;

            // Stage 1: capture operands and beat control while enabled.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s1_a_q     <= '0;
                    s1_b_q     <= '0;
                    s1_c_q     <= '0;
                    s1_mode_q  <= 2'b00;
                    s1_clr_q   <= 1'b0;
                    s1_valid_q <= 1'b0;
                end else if (en) begin
                    s1_a_q     <= a;
                    s1_b_q     <= b;
                    s1_c_q     <= c;
                    s1_mode_q  <= mode;
                    s1_clr_q   <= acc_clr;
                    s1_valid_q <= in_valid;
                end
            end

            assign s1_p_s = smul(s1_a_q, s1_b_q);

            if (lat == 2) begin : g_lat2
                // Stage 1 feeds the output stage directly.
                always_comb begin
                    fin_p_s     = s1_p_s;
                    fin_c_s     = s1_c_q;
                    fin_mode_s  = s1_mode_q;
                    fin_clr_s   = s1_clr_q;
                    fin_valid_s = s1_valid_q;
                end
            end else begin : g_chain
                logic [PW-1:0]    pp_q [PD];
                logic [width-1:0] pc_q [PD];
                logic [1:0]       pm_q [PD];
                logic             pk_q [PD];
                logic             pv_q [PD];

                // Middle stages carry the product and control towards the output.
                always_ff @(posedge clock or negedge reset) begin
                    if (!reset) begin
                        for (int i = 0; i < PD; i++) begin
                            pp_q[i] <= '0;
                            pc_q[i] <= '0;
                            pm_q[i] <= 2'b00;
                            pk_q[i] <= 1'b0;
                            pv_q[i] <= 1'b0;
                        end
                    end else if (en) begin
                        pp_q[0] <= s1_p_s;
                        pc_q[0] <= s1_c_q;
                        pm_q[0] <= s1_mode_q;
                        pk_q[0] <= s1_clr_q;
                        pv_q[0] <= s1_valid_q;
                        for (int i = 1; i < PD; i++) begin
                            pp_q[i] <= pp_q[i-1];
                            pc_q[i] <= pc_q[i-1];
                            pm_q[i] <= pm_q[i-1];
                            pk_q[i] <= pk_q[i-1];
                            pv_q[i] <= pv_q[i-1];
                        end
                    end
                end

                // Last middle stage feeds the output stage.
                always_comb begin
                    fin_p_s     = pp_q[PD-1];
                    fin_c_s     = pc_q[PD-1];
                    fin_mode_s  = pm_q[PD-1];
                    fin_clr_s   = pk_q[PD-1];
                    fin_valid_s = pv_q[PD-1];
                end
            end
        end
    endgenerate

    // Output stage state.
    logic [acc_width-1:0] acc_q, acc_d;
    logic [width-1:0]     y_q, y_d;
    logic                 ovf_q, ovf_d;
    logic                 out_valid_q, out_valid_d;

    // Final-add intermediates.
    logic [RW-1:0]        p_ext_s;
    logic [RW-1:0]        c_ext_s;
    logic [acc_width-1:0] acc_base_s;
    logic [acc_width-1:0] acc_sum_s;
    logic [RW-1:0]        r_s;
    logic [RW-width:0]    r_hi_s;
    logic                 r_ovf_s;
    logic [width-1:0]     r_y_s;
    logic                 take_s;

    // Final add, range check and next-state selection for the output stage.
    always_comb begin
        p_ext_s    = RW'($signed(fin_p_s));
        c_ext_s    = RW'($signed(fin_c_s));
        acc_base_s = fin_clr_s ? {acc_width{1'b0}} : acc_q;
        acc_sum_s  = acc_base_s + acc_width'($signed(fin_p_s));
        case (fin_mode_s)
            2'b00:   r_s = p_ext_s + c_ext_s;
            2'b01:   r_s = p_ext_s - c_ext_s;
            2'b10:   r_s = RW'($signed(acc_sum_s));
            2'b11:   r_s = p_ext_s;
            default: r_s = p_ext_s;
        endcase
        // r fits in width signed bits only if all bits from width-1 up agree.
        r_hi_s  = r_s[RW-1:width-1];
        r_ovf_s = !((&r_hi_s) || (~|r_hi_s));
`ifdef DSP_MULADD_SAT_EN
        if (r_ovf_s) begin
            r_y_s = sat_value(r_s[RW-1]);
        end else begin
            r_y_s = r_s[width-1:0];
        end
`else
        r_y_s = r_s[width-1:0];
`endif
        take_s = en && fin_valid_s;

        out_valid_d = out_valid_q;
        y_d         = y_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        if (en) begin
            out_valid_d = fin_valid_s;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (take_s) begin
            y_d   = r_y_s;
            ovf_d = r_ovf_s;
        end else begin
            y_d   = y_q;
            ovf_d = ovf_q;
        end
        if (take_s && (fin_mode_s == 2'b10)) begin
            acc_d = acc_sum_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Output stage and accumulator registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q       <= '0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/dsp_muladd_pipe.md
Name: dsp_muladd_pipe

Overview:
Parametrised successor to the single-stage DSP add/register/multiply primitive. It computes signed multiply-add, multiply-subtract, multiply-accumulate or multiply-only results over a configurable-depth pipeline. A valid flag travels with each beat, and a global enable stalls the whole pipe. It sits in the ultrascale primitive library as the generic arithmetic target for pipelined mul/add instructions.

Parameters:
- width, 8, operand and result width in bits; legal range 2..24.
- lat, 2, pipeline latency in cycles from input sample to registered output; legal range 1..4.
- acc_width, 48, accumulator width; must be >= 2*width.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- en  in  1  pipeline enable; 0 freezes every stage.
- in_valid  in  1  input beat valid.
- mode  in  2  operation select, travels down the pipe with the beat.
- acc_clr  in  1  accumulator restart flag, travels down the pipe with the beat.
- a  in  width  signed multiplicand.
- b  in  width  signed multiplier.
- c  in  width  signed addend/subtrahend.
- out_valid  out  1  result valid.
- y  out  width  signed result.
- overflow  out  1  set when the full-precision result does not fit in width signed bits.

Behaviour:
- Reset (reset=0, asynchronous): all stage registers, the accumulator, out_valid, y and overflow go to 0 immediately. Release is synchronous to clock.
- Stage 1 registers a, b, c, mode, acc_clr and in_valid when en=1.
- The product p = a*b is signed, 2*width bits.
- Stages 2..lat carry p and the control signals. The final add is done in the last stage. For lat=1, the multiply and add sit in one stage.
- Mode 00: r = p + sext(c).
- Mode 01: r = p - sext(c).
- Mode 10: acc_next = (acc_clr ? 0 : acc) + sext(p), held at acc_width bits; r = acc_next.
- Mode 11: r = p.
- Width rule: r is computed at max(2*width+1, acc_width) bits; y = r[width-1:0] (wrap).
- overflow = 1 when r is outside [-2^(width-1), 2^(width-1)-1]; it is registered alongside y.
- The accumulator updates only when a valid beat with mode 10 reaches the output stage with en=1. Beats in other modes and bubbles leave acc unchanged.
- Latency: a beat sampled with en=1 appears with out_valid=1 exactly lat enabled cycles later. Each en=0 cycle adds one cycle of delay.
- en=0 holds every stage, including out_valid, y, overflow and acc. No beat is lost or duplicated.
- Bubbles: in_valid=0 propagates as out_valid=0. y and overflow hold their last valid values while out_valid=0.
- Full throughput: one beat per cycle while en=1. No backpressure beyond en.
- acc_clr on a beat whose mode is not 10 has no effect.
- Reset mid-operation flushes all in-flight beats. The first post-reset out_valid appears no earlier than lat cycles after the first post-reset sample.

Optional Feature:
- Macro: DSP_MULADD_SAT_EN.
- Defined: when overflow=1, y saturates to 2^(width-1)-1 (positive r) or -2^(width-1) (negative r). The accumulator itself never saturates and stays full-precision.
- Undefined: y wraps to the low width bits as above. overflow behaves identically in both builds.

Test Plan:
- width=8, lat=2, mode=00, a=3, b=4, c=5, en=1 → out_valid=1 two cycles later, y=17, overflow=0.
- mode=01, a=-2, b=7, c=10 → y=-24 (0xE8), overflow=0.
- mode=10, back-to-back beats (2,3 with acc_clr=1), (4,5), (1,1) → y=6, 26, 27 on consecutive cycles. A fourth beat (1,1) with acc_clr=1 → y=1.
- Beat a=3, b=4, c=5 issued, then en=0 for 3 cycles mid-flight → out_valid, y and acc frozen; y=17 appears 5 cycles after issue, exactly once.
- mode=00, a=127, b=127, c=0 → overflow=1. Without DSP_MULADD_SAT_EN, y=0x01. With it, y=127. Then a=-128, b=127, c=-1 → saturated build gives y=-128.
- Accumulate to acc=26, then drive reset=0 asynchronously between clock edges → out_valid, y, overflow and acc read 0 before the next edge. After release, the next mode-10 beat (2,2) without acc_clr → y=4.
